// File: rtl/deep3_pkg.sv
// Shared constants, leaf indices and FSM encoding for the 3-level logic-tree preimage enumerator.
package deep3_pkg;
    localparam int VEC_W      = 8;
    localparam int TOTAL_VECS = 256;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int A_IDX = 0;
    localparam int B_IDX = 1;
    localparam int C_IDX = 2;
    localparam int D_IDX = 3;
    localparam int E_IDX = 4;
    localparam int F_IDX = 5;
    localparam int G_IDX = 6;
    localparam int H_IDX = 7;

    // Number of vectors mapping to each output value of the tree.
    localparam int Y1_HITS = 130;
    localparam int Y0_HITS = 126;
endpackage

// File: rtl/deep_3level_eval.sv
// Combinational evaluation of y = ((a&b)|(c&d)) ^ ((e|f)&(g|h)); zero latency, no flow control.
module deep_3level_eval
    import deep3_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             y
);
    assign y = ((vec[A_IDX] & vec[B_IDX]) | (vec[C_IDX] & vec[D_IDX]))
             ^ ((vec[E_IDX] | vec[F_IDX]) & (vec[G_IDX] | vec[H_IDX]));
endmodule

// File: rtl/deep_3level_preimage_enum.sv
// Walks all 256 input vectors and streams those whose tree output equals the target.
// Latency: a hit on cnt at edge N is valid after edge N, 1 vector/cycle; out_vec held while stalled.
// Optional DEEP3_PREIMAGE_CHECK_EN adds an independent re-evaluation of out_vec driving check_err.
module deep_3level_preimage_enum
    import deep3_pkg::*;
#(
    parameter int MAX_HITS = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             target,
    input  logic             abort,
    output logic [VEC_W-1:0] out_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [8:0]       hit_count,
    output logic             check_err
);
    localparam logic [8:0] MAX_M1 = 9'(MAX_HITS - 1);

    state_t           state;
    logic [VEC_W-1:0] cnt;
    logic             tgt;
    logic             cnt_y;
    logic             match;
    logic             hs;
    logic             slot_free;
    logic             emit;
    logic             advance;
    logic             run_end;

    deep_3level_eval u_eval (
        .vec (cnt),
        .y   (cnt_y)
    );

    assign match     = (state == RUN) && (cnt_y == tgt);
    assign hs        = out_valid && out_ready;
    assign slot_free = !out_valid || out_ready;
    assign emit      = match && slot_free;
    // A stalled hit holds cnt; a non-hit always moves on.
    assign advance   = (state == RUN) && (!match || slot_free);
    assign run_end   = advance && ((cnt == 8'hFF) || (emit && (hit_count == MAX_M1)));

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tgt       <= 1'b0;
            out_vec   <= '0;
            out_valid <= 1'b0;
            hit_count <= '0;
        end else if (abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        cnt       <= '0;
                        hit_count <= '0;
                        tgt       <= target;
                    end
                end
                RUN: begin
                    if (emit) begin
                        out_vec   <= cnt;
                        out_valid <= 1'b1;
                        hit_count <= hit_count + 9'd1;
                    end else if (hs) begin
                        out_valid <= 1'b0;
                    end
                    if (advance && (cnt != 8'hFF)) begin
                        cnt <= cnt + 8'd1;
                    end
                    if (run_end) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                    end
                    if (!out_valid) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DEEP3_PREIMAGE_CHECK_EN
    logic chk_y;

    deep_3level_eval u_chk_eval (
        .vec (out_vec),
        .y   (chk_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            check_err <= 1'b0;
        end else if ((state == IDLE) && start && !abort) begin
            check_err <= 1'b0;
        end else if (out_valid && (chk_y != tgt)) begin
            check_err <= 1'b1;
        end
    end
`else
    assign check_err = 1'b0;
`endif
endmodule

// File: tb/tb_deep_3level_preimage_enum.sv
// Directed, table-driven bench for deep_3level_preimage_enum plus hand-written abort/reset/MAX_HITS sequences.
module tb_deep_3level_preimage_enum;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       start4;
    logic       target;
    logic       abort;
    logic       out_ready;
    logic [7:0] out_vec,   out_vec4;
    logic       out_valid, out_valid4;
    logic       busy,      busy4;
    logic       done,      done4;
    logic [8:0] hit_count, hit_count4;
    logic       check_err, check_err4;

    deep_3level_preimage_enum #(.MAX_HITS(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .target(target), .abort(abort),
        .out_vec(out_vec), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .hit_count(hit_count), .check_err(check_err)
    );

    deep_3level_preimage_enum #(.MAX_HITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .target(target), .abort(abort),
        .out_vec(out_vec4), .out_valid(out_valid4), .out_ready(out_ready),
        .busy(busy4), .done(done4), .hit_count(hit_count4), .check_err(check_err4)
    );

    typedef struct {
        logic       tgt;
        int         mode;      // 0 ready always, 1 random, 2 alternating, 3 manual
        logic       mid_start;
        logic [8:0] exp_first;
        logic [8:0] exp_second;
        logic [8:0] exp_last;
        int         exp_cnt;
    } row_t;

    int         n_cmp = 0;
    int         n_err = 0;
    int         mode = 3;
    int         done_cnt = 0;
    int         done4_cnt = 0;
    int         stall_err = 0;
    logic [7:0] got[$];
    logic [7:0] got4[$];
    logic       prev_stall = 1'b0;
    logic       prev_abort = 1'b0;
    logic [7:0] prev_vec = '0;
    row_t       rows[5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_y(input logic [7:0] v);
        logic a, b, c, d, e, f, g, h;
        {h, g, f, e, d, c, b, a} = v;
        return ((a & b) | (c & d)) ^ ((e | f) & (g | h));
    endfunction

    // Ready driver: updates shortly after each rising edge unless under manual control.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = !out_ready;
                default: ;
            endcase
        end
    end

    // Handshakes are judged at the falling edge, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (out_valid && out_ready) got.push_back(out_vec);
        if (out_valid4 && out_ready) got4.push_back(out_vec4);
        if (done) done_cnt++;
        if (done4) done4_cnt++;
        if (rst_n && prev_stall && !prev_abort && (!out_valid || out_vec != prev_vec)) stall_err++;
        prev_stall = out_valid && !out_ready;
        prev_abort = abort;
        prev_vec   = out_vec;
    end

    task automatic pulse_start(input logic tgt);
        @(posedge clk); #1;
        target = tgt;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        target = ~tgt;
    endtask

    task automatic run_row(input row_t r);
        logic [7:0] exp_q[$];
        logic [8:0] f, s, l;
        int         waited = 0;
        int         errs = 0;
        for (int v = 0; v < 256; v++) if (model_y(8'(v)) == r.tgt) exp_q.push_back(8'(v));
        got.delete();
        done_cnt  = 0;
        stall_err = 0;
        mode      = r.mode;
        pulse_start(r.tgt);
        if (r.mid_start) begin
            repeat (20) @(posedge clk);
            #1;
            chk("busy_mid", 32'(busy), 32'd1);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        while (done_cnt == 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        chk("done_timeout", 32'(waited < 3000), 32'd1);
        repeat (4) @(negedge clk);
        f = (got.size() > 0) ? {1'b0, got[0]} : 9'h1FF;
        s = (got.size() > 1) ? {1'b0, got[1]} : 9'h1FF;
        l = (got.size() > 0) ? {1'b0, got[got.size()-1]} : 9'h1FF;
        chk("first_vec", 32'(f), 32'(r.exp_first));
        chk("second_vec", 32'(s), 32'(r.exp_second));
        chk("last_vec", 32'(l), 32'(r.exp_last));
        chk("num_hits", 32'(got.size()), 32'(r.exp_cnt));
        chk("hit_count", 32'(hit_count), 32'(r.exp_cnt));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] != exp_q[i]) errs++;
        chk("sequence", 32'(errs), 32'd0);
        chk("stall_stable", 32'(stall_err), 32'd0);
        chk("check_err", 32'(check_err), 32'd0);
    endtask

    initial begin
        int w;
        rows[0] = '{tgt: 1'b1, mode: 0, mid_start: 1'b0, exp_first: 9'h03, exp_second: 9'h07, exp_last: 9'hFA, exp_cnt: 130};
        rows[1] = '{tgt: 1'b0, mode: 0, mid_start: 1'b0, exp_first: 9'h00, exp_second: 9'h01, exp_last: 9'hFF, exp_cnt: 126};
        rows[2] = '{tgt: 1'b1, mode: 1, mid_start: 1'b0, exp_first: 9'h03, exp_second: 9'h07, exp_last: 9'hFA, exp_cnt: 130};
        rows[3] = '{tgt: 1'b0, mode: 2, mid_start: 1'b0, exp_first: 9'h00, exp_second: 9'h01, exp_last: 9'hFF, exp_cnt: 126};
        rows[4] = '{tgt: 1'b1, mode: 0, mid_start: 1'b1, exp_first: 9'h03, exp_second: 9'h07, exp_last: 9'hFA, exp_cnt: 130};

        rst_n = 1'b0; start = 1'b0; start4 = 1'b0; target = 1'b0; abort = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_out_vec", 32'(out_vec), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hit_count", 32'(hit_count), 32'd0);
        chk("rst_check_err", 32'(check_err), 32'd0);
        #10 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_row(rows[i]);

        // MAX_HITS=4 instance stops after the first four hits.
        mode = 0;
        got4.delete();
        done4_cnt = 0;
        @(posedge clk); #1;
        target = 1'b1; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        w = 0;
        while (done4_cnt == 0 && w < 1000) begin @(negedge clk); w++; end
        chk("max4_timeout", 32'(w < 1000), 32'd1);
        repeat (3) @(negedge clk);
        chk("max4_num", 32'(got4.size()), 32'd4);
        if (got4.size() == 4) begin
            chk("max4_v0", 32'(got4[0]), 32'h03);
            chk("max4_v1", 32'(got4[1]), 32'h07);
            chk("max4_v2", 32'(got4[2]), 32'h0B);
            chk("max4_v3", 32'(got4[3]), 32'h0C);
        end
        chk("max4_hit_count", 32'(hit_count4), 32'd4);
        chk("max4_done", 32'(done4_cnt), 32'd1);

        // Abort with the 10th hit (0x1B) stalled.
        mode = 3;
        out_ready = 1'b1;
        got.delete();
        done_cnt = 0;
        pulse_start(1'b1);
        w = 0;
        while (hit_count != 9'd10 && w < 1000) begin @(posedge clk); #1; w++; end
        out_ready = 1'b0;
        chk("abort_reach10", 32'(w < 1000), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_vec", 32'(out_vec), 32'h1B);
        chk("stall_hits", 32'(hit_count), 32'd10);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_hits", 32'(hit_count), 32'd10);
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_accepted", 32'(got.size()), 32'd9);
        out_ready = 1'b1;
        run_row(rows[0]);

        // Simultaneous start and abort in IDLE: abort wins.
        @(posedge clk); #1;
        target = 1'b1; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a run.
        mode = 0;
        pulse_start(1'b1);
        repeat (30) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_vec", 32'(out_vec), 32'd0);
        chk("mid_rst_hits", 32'(hit_count), 32'd0);
        #5 rst_n = 1'b1;
        run_row(rows[4]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
